// File: rtl/ysyx_24070014_lsu.sv
// Load/store unit: one request at a time onto a word-aligned valid/ready memory bus,
// with byte strobes, load extension, misalignment detection and a bus timeout.
module ysyx_24070014_lsu #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic [1:0]          resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                write_q, write_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                misaligned;
  logic [DATA_LEN-1:0] lane_wdata;
  logic [3:0]          lane_wstrb;
  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-1:0] load_data;
  logic [7:0]          cnt_inc;

  always_comb begin
    misaligned = (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (req_size == 2'b11);
  end

  always_comb begin
    lane_wdata = req_wdata;
    lane_wstrb = 4'b1111;
    case (req_size)
      2'b00: begin
        lane_wdata = {(DATA_LEN/8){req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {(DATA_LEN/16){req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {{(DATA_LEN-8){1'b0}}, shifted[7:0]}
                                 : {{(DATA_LEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {{(DATA_LEN-16){1'b0}}, shifted[15:0]}
                                 : {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          write_d = req_write;
          wdata_d = lane_wdata;
          wstrb_d = req_write ? lane_wstrb : 4'b0000;
          rdata_d = '0;
          cnt_d   = '0;
          if (misaligned) begin
            state_d = S_RESP;
            err_d   = ERR_ALIGN;
          end else begin
            state_d = S_REQ;
            err_d   = ERR_OK;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // The awaited event is tested before the limit so a coincident event wins.
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = write_q ? S_RESP : S_WAIT;
        end else if (cnt_inc == TMO_LIMIT) begin
          state_d = S_RESP;
          err_d   = ERR_TMO;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = load_data;
        end else if (cnt_inc == TMO_LIMIT) begin
          state_d = S_RESP;
          err_d   = ERR_TMO;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = '0;
        err_d   = ERR_OK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state_q == S_REQ);
  assign mem_addr   = {addr_q[ADDR_LEN-1:2], 2'b00};
  assign mem_wen    = write_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Directed self-checking bench for ysyx_24070014_lsu: loads, stores, misalignment,
// timeout, event/limit coincidence and asynchronous reset mid-transaction.
module tb_ysyx_24070014_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  ysyx_24070014_lsu #(
    .DATA_LEN(32),
    .ADDR_LEN(32),
    .TIMEOUT (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s: observed=%h expected=%h", tag, name, obs, exp);
    end
  endtask

  task automatic present(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [31:0] exp);
    chk(tag, "ready_idle", {31'b0, req_ready}, 32'd1);
    present(1'b0, size, uns, addr, 32'h5A5A_5A5A);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk(tag, "mem_valid_c1", {31'b0, mem_valid}, 32'd1);
    chk(tag, "mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk(tag, "mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk(tag, "mem_wen", {31'b0, mem_wen}, 32'd0);
    chk(tag, "ready_busy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk(tag, "mem_valid_c2", {31'b0, mem_valid}, 32'd0);
    chk(tag, "resp_valid_c2", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk(tag, "resp_valid_c3", {31'b0, resp_valid}, 32'd1);
    chk(tag, "resp_rdata", resp_rdata, exp);
    chk(tag, "resp_err", {30'b0, resp_err}, 32'd0);
    @(negedge clk);
    chk(tag, "resp_valid_c4", {31'b0, resp_valid}, 32'd0);
    chk(tag, "resp_rdata_clr", resp_rdata, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [31:0] exp_wd,
                          input logic [3:0] exp_strb);
    chk(tag, "ready_idle", {31'b0, req_ready}, 32'd1);
    present(1'b1, size, 1'b0, addr, wd);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk(tag, "mem_valid_c1", {31'b0, mem_valid}, 32'd1);
    chk(tag, "mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk(tag, "mem_wen", {31'b0, mem_wen}, 32'd1);
    chk(tag, "mem_wdata", mem_wdata, exp_wd);
    chk(tag, "mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
    @(negedge clk);
    chk(tag, "resp_valid_c2", {31'b0, resp_valid}, 32'd1);
    chk(tag, "resp_rdata", resp_rdata, 32'd0);
    chk(tag, "resp_err", {30'b0, resp_err}, 32'd0);
    chk(tag, "mem_valid_c2", {31'b0, mem_valid}, 32'd0);
    @(negedge clk);
    chk(tag, "resp_valid_c3", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic do_mis(input string tag, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr);
    present(wr, size, 1'b0, addr, 32'h1234_5678);
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk(tag, "mem_valid_c1", {31'b0, mem_valid}, 32'd0);
    chk(tag, "resp_valid_c1", {31'b0, resp_valid}, 32'd1);
    chk(tag, "resp_err", {30'b0, resp_err}, 32'd1);
    chk(tag, "resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk(tag, "mem_valid_c2", {31'b0, mem_valid}, 32'd0);
    chk(tag, "resp_valid_c2", {31'b0, resp_valid}, 32'd0);
    chk(tag, "resp_err_clr", {30'b0, resp_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    #1;
    chk("rst", "req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst", "resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst", "resp_rdata", resp_rdata, 32'd0);
    chk("rst", "resp_err", {30'b0, resp_err}, 32'd0);
    chk("rst", "mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst", "mem_addr", mem_addr, 32'd0);
    chk("rst", "mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst", "mem_wdata", mem_wdata, 32'd0);
    chk("rst", "mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_load("lw",  32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  32'h8000_0003, 2'b00, 1'b0, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu", 32'h8000_0003, 2'b00, 1'b1, 32'h8012_3456, 32'h0000_0080);
    do_load("lh",  32'h8000_0002, 2'b01, 1'b0, 32'h8001_5555, 32'hFFFF_8001);
    do_load("lhu", 32'h8000_0000, 2'b01, 1'b1, 32'h1234_ABCD, 32'h0000_ABCD);
    do_load("lb1", 32'h8000_0001, 2'b00, 1'b0, 32'h0000_7F00, 32'h0000_007F);

    do_store("sb", 32'h8000_0002, 2'b00, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0100);
    do_store("sh", 32'h8000_0002, 2'b01, 32'h0000_1234, 32'h1234_1234, 4'b1100);
    do_store("sw", 32'h8000_0008, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

    do_mis("mis_lw", 1'b0, 2'b10, 32'h8000_0002);
    do_mis("mis_sh", 1'b1, 2'b01, 32'h8000_0001);
    do_mis("mis_sz3", 1'b0, 2'b11, 32'h8000_0000);

    // rvalid while still in REQ must not complete the load
    present(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("early", "resp_valid_c2", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("early", "resp_valid_c3", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("early", "resp_valid_c4", {31'b0, resp_valid}, 32'd1);
    chk("early", "resp_rdata", resp_rdata, 32'h2222_2222);
    @(negedge clk);

    // mem_ready withheld: mem_valid stays up for TIMEOUT cycles, then err=10
    present(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (mem_valid === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo", "req_cycles", cnt, 32'd255);
    chk("tmo", "resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("tmo", "resp_err", {30'b0, resp_err}, 32'd2);
    chk("tmo", "resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("tmo", "mem_valid_after", {31'b0, mem_valid}, 32'd0);
    chk("tmo", "resp_valid_after", {31'b0, resp_valid}, 32'd0);
    do_store("post_tmo", 32'h8000_0004, 2'b10, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'b1111);

    // mem_ready arrives exactly at the limit cycle: event wins
    present(1'b1, 2'b10, 1'b0, 32'h8000_0030, 32'h7777_7777);
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (254) @(negedge clk);
    chk("edge", "mem_valid_255", {31'b0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("edge", "resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("edge", "resp_err", {30'b0, resp_err}, 32'd0);
    @(negedge clk);

    // asynchronous reset while waiting for read data
    present(1'b0, 2'b10, 1'b0, 32'h8000_0040, 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst", "mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("arst", "req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst", "mem_addr", mem_addr, 32'd0);
    chk("arst", "resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h3333_3333;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("arst", "no_resp_1", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("arst", "no_resp_2", {31'b0, resp_valid}, 32'd0);
    chk("arst", "rdata", resp_rdata, 32'd0);

    do_load("post_rst", 32'h8000_0004, 2'b10, 1'b0, 32'h0102_0304, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
